// File: rtl/seq_bin_div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
// Imported by the divider top and its compare/subtract helper.
package seq_bin_div_pkg;

    localparam int DIV_DP_WIDTH = 8;
    localparam int DIV_BC_SIZE  = 4;

    typedef enum logic [1:0] {
        S_idle  = 2'd0,
        S_check = 2'd1,
        S_shift = 2'd2,
        S_sub   = 2'd3
    } div_state_e;

    // Iteration count loaded into the bit counter on an accepted start.
    function automatic logic [DIV_BC_SIZE-1:0] div_count_init(input int width);
        div_count_init = DIV_BC_SIZE'(width);
    endfunction

endpackage

// File: rtl/seq_bin_div_sub_cmp.sv
// (W+1)-bit unsigned compare and subtract of {E,A} against {1'b0,B}.
// Shared by the overflow check and every restoring step.
module div_sub_cmp
    import seq_bin_div_pkg::*;
#(
    parameter int w = DIV_DP_WIDTH
) (
    input  logic [w:0]   lhs,
    input  logic [w-1:0] rhs,
    output logic         ge,
    output logic [w:0]   diff
);

    logic [w:0] rhs_ext;

    assign rhs_ext = {1'b0, rhs};
    assign ge      = (lhs >= rhs_ext);
    assign diff    = lhs - rhs_ext;

endmodule

// File: rtl/seq_bin_div.sv
// Sequential restoring (shift-subtract) divider: 2W-bit dividend / W-bit divisor.
// Controller and datapath share one file; start/rdy handshake matches the shift-add multiplier.
module seq_bin_div
    import seq_bin_div_pkg::*;
#(
    parameter int dp_width = DIV_DP_WIDTH,
    parameter int bc_size  = DIV_BC_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2*dp_width-1:0]   dividend,
    input  logic [dp_width-1:0]     divisor,
    output logic [dp_width-1:0]     quotient,
    output logic [dp_width-1:0]     remainder,
    output logic                    ovf,
    output logic                    dz,
    output logic                    rdy
);

    div_state_e state_q, state_d;

    logic [dp_width-1:0] a_q, a_d;
    logic [dp_width-1:0] q_q, q_d;
    logic [dp_width-1:0] b_q, b_d;
    logic                e_q, e_d;
    logic [bc_size-1:0]  p_q, p_d;
    logic                ovf_q, ovf_d;
    logic                dz_q, dz_d;
    logic                rdy_q, rdy_d;

    logic load_regs;
    logic shift_regs;
    logic sub_regs;
    logic decr_p;
    logic set_ovf;

    logic                cmp_ge;
    logic [dp_width:0]   cmp_diff;
    logic                p_zero;
    logic                b_zero;

    assign p_zero = (p_q == {bc_size{1'b0}});
    assign b_zero = (b_q == {dp_width{1'b0}});

    // In S_check E is still 0, so the same comparator answers A >= B.
    div_sub_cmp #(
        .w (dp_width)
    ) u_sub_cmp (
        .lhs  ({e_q, a_q}),
        .rhs  (b_q),
        .ge   (cmp_ge),
        .diff (cmp_diff)
    );

    // Controller: next state and datapath control strobes.
    always_comb begin
        state_d    = state_q;
        load_regs  = 1'b0;
        shift_regs = 1'b0;
        sub_regs   = 1'b0;
        decr_p     = 1'b0;
        set_ovf    = 1'b0;
        case (state_q)
            S_idle: begin
                if (start) begin
                    load_regs = 1'b1;
                    state_d   = S_check;
                end else begin
                    state_d   = S_idle;
                end
            end
            S_check: begin
                if (cmp_ge) begin
                    set_ovf = 1'b1;
                    state_d = S_idle;
                end else begin
                    state_d = S_shift;
                end
            end
            S_shift: begin
                shift_regs = 1'b1;
                decr_p     = 1'b1;
                state_d    = S_sub;
            end
            S_sub: begin
                sub_regs = 1'b1;
                if (p_zero) begin
                    state_d = S_idle;
                end else begin
                    state_d = S_shift;
                end
            end
            default: begin
                state_d = S_idle;
            end
        endcase
    end

    // Datapath: register next values under the controller strobes.
    always_comb begin
        a_d   = a_q;
        q_d   = q_q;
        b_d   = b_q;
        e_d   = e_q;
        p_d   = p_q;
        ovf_d = ovf_q;
        dz_d  = dz_q;
        if (load_regs) begin
            a_d   = dividend[2*dp_width-1:dp_width];
            q_d   = dividend[dp_width-1:0];
            b_d   = divisor;
            e_d   = 1'b0;
            p_d   = div_count_init(dp_width);
            ovf_d = 1'b0;
            dz_d  = 1'b0;
        end else if (set_ovf) begin
            ovf_d = 1'b1;
            dz_d  = b_zero;
        end else if (shift_regs) begin
            e_d = a_q[dp_width-1];
            a_d = {a_q[dp_width-2:0], q_q[dp_width-1]};
            q_d = {q_q[dp_width-2:0], 1'b0};
        end else if (sub_regs) begin
            if (cmp_ge) begin
                a_d    = cmp_diff[dp_width-1:0];
                q_d[0] = 1'b1;
                e_d    = 1'b0;
            end else begin
                a_d = a_q;
            end
        end else begin
            a_d = a_q;
        end
        // The counter saturates at zero rather than wrapping.
        if (decr_p && !p_zero) begin
            p_d = p_q - {{(bc_size-1){1'b0}}, 1'b1};
        end else begin
            p_d = p_d;
        end
        rdy_d = (state_d == S_idle);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_idle;
            a_q     <= {dp_width{1'b0}};
            q_q     <= {dp_width{1'b0}};
            b_q     <= {dp_width{1'b0}};
            e_q     <= 1'b0;
            p_q     <= {bc_size{1'b0}};
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            b_q     <= b_d;
            e_q     <= e_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            rdy_q   <= rdy_d;
        end
    end

    assign quotient  = q_q;
    assign remainder = a_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;
    assign rdy       = rdy_q;

endmodule

// File: tb/tb_seq_bin_div.sv
// Self-checking bench for seq_bin_div (W=8): directed cases, random cases against
// an arithmetic reference, mid-operation start/reset and back-to-back starts.
module tb_seq_bin_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dz;
    logic        rdy;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_bin_div dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .dz        (dz),
        .rdy       (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division; on overflow the registers keep the dividend halves.
    // lat is the number of cycles rdy stays low after the accepting edge.
    task automatic ref_div(input logic [15:0] dd, input logic [7:0] dv,
                           output logic [7:0] eq, output logic [7:0] er,
                           output logic eovf, output logic edz, output int lat);
        int unsigned hi;
        hi = dd / 256;
        if (dv == 8'd0 || hi >= dv) begin
            eovf = 1'b1;
            edz  = (dv == 8'd0);
            eq   = dd[7:0];
            er   = dd[15:8];
            lat  = 1;
        end else begin
            eovf = 1'b0;
            edz  = 1'b0;
            eq   = 8'(dd / dv);
            er   = 8'(dd % dv);
            lat  = 17;
        end
    endtask

    // Launch one division and wait (bounded) for rdy; cyc = cycles rdy was low.
    task automatic do_div(input logic [15:0] dd, input logic [7:0] dv, output int cyc);
        int guard;
        guard = 0;
        while (!rdy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = 16'd0;
        divisor = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({rdy, ovf, dz, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset: got rdy=%0b ovf=%0b dz=%0b q=%0d r=%0d, want rdy=1 ovf=0 dz=0 q=0 r=0",
                     rdy, ovf, dz, quotient, remainder);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [15:0] dds [4] = '{16'd100, 16'hFEFF, 16'h0700, 16'd50};
        logic [7:0]  dvs [4] = '{8'd7, 8'hFF, 8'd7, 8'd0};
        logic [7:0]  wq  [4] = '{8'd14, 8'd255, 8'h00, 8'd50};
        logic [7:0]  wr  [4] = '{8'd2, 8'd254, 8'h07, 8'd0};
        logic        wo  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic        wz  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        int          wl  [4] = '{17, 17, 1, 1};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            do_div(dds[i], dvs[i], cyc);
            n_cmp++;
            if ({quotient, remainder, ovf, dz} !== {wq[i], wr[i], wo[i], wz[i]} || cyc != wl[i]) begin
                n_fail++;
                $display("FAIL directed %0d/%0d: got q=%0d r=%0d ovf=%0b dz=%0b busy=%0d, want q=%0d r=%0d ovf=%0b dz=%0b busy=%0d",
                         dds[i], dvs[i], quotient, remainder, ovf, dz, cyc,
                         wq[i], wr[i], wo[i], wz[i], wl[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] dd;
        logic [7:0]  dv, eq, er;
        logic        eo, ez;
        int          el, cyc;
        for (int i = 0; i < 40; i++) begin
            dv = 8'($urandom_range(0, 255));
            if (dv != 8'd0 && ($urandom % 4) != 0) begin
                dd = {8'($urandom_range(0, int'(dv) - 1)), 8'($urandom_range(0, 255))};
            end else begin
                dd = 16'($urandom_range(0, 65535));
            end
            ref_div(dd, dv, eq, er, eo, ez, el);
            do_div(dd, dv, cyc);
            n_cmp++;
            if ({quotient, remainder, ovf, dz} !== {eq, er, eo, ez} || cyc != el) begin
                n_fail++;
                $display("FAIL random %0d/%0d: got q=%0d r=%0d ovf=%0b dz=%0b busy=%0d, want q=%0d r=%0d ovf=%0b dz=%0b busy=%0d",
                         dd, dv, quotient, remainder, ovf, dz, cyc, eq, er, eo, ez, el);
            end
        end
    endtask

    task automatic test_mid_start_and_reset();
        int cyc;
        dividend = 16'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!rdy && cyc < 50) begin
            if (cyc == 5) begin
                dividend = 16'd200;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if ({quotient, remainder, ovf, dz} !== {8'd14, 8'd2, 1'b0, 1'b0} || cyc != 17) begin
            n_fail++;
            $display("FAIL mid_start: got q=%0d r=%0d ovf=%0b dz=%0b busy=%0d, want q=14 r=2 ovf=0 dz=0 busy=17",
                     quotient, remainder, ovf, dz, cyc);
        end
        dividend = 16'd1234;
        divisor  = 8'd99;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        n_cmp++;
        if (rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_before_rst: got rdy=%0b, want rdy=0", rdy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({rdy, ovf, dz, quotient, remainder} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL mid_reset: got rdy=%0b ovf=%0b dz=%0b q=%0d r=%0d, want rdy=1 ovf=0 dz=0 q=0 r=0",
                     rdy, ovf, dz, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dds [3] = '{16'd100, 16'd255, 16'd0};
        logic [7:0]  dvs [3] = '{8'd7, 8'd16, 8'd1};
        logic [7:0]  eq, er;
        logic        eo, ez;
        int          el, cyc;
        dividend = dds[0];
        divisor  = dvs[0];
        start    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_accept %0d: got rdy=%0b, want rdy=0", i, rdy);
            end
            if (i < 2) begin
                dividend = dds[i+1];
                divisor  = dvs[i+1];
            end else begin
                start = 1'b0;
            end
            cyc = 0;
            while (!rdy && cyc < 50) begin
                @(posedge clk); #1;
                cyc++;
            end
            ref_div(dds[i], dvs[i], eq, er, eo, ez, el);
            n_cmp++;
            if ({quotient, remainder, ovf, dz} !== {eq, er, eo, ez} || cyc != el) begin
                n_fail++;
                $display("FAIL b2b %0d: got q=%0d r=%0d ovf=%0b dz=%0b busy=%0d, want q=%0d r=%0d ovf=%0b dz=%0b busy=%0d",
                         i, quotient, remainder, ovf, dz, cyc, eq, er, eo, ez, el);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_mid_start_and_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
